// File: rtl/bus_target_pkg.sv
// ============================================================================
// Module : bus_target_pkg
// Brief  : Bus cycle types and status decode for the V33 bus target.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_target_pkg;

  typedef enum logic [2:0] {
    CYC_NONE,
    CYC_INT_ACK,
    CYC_IO_RD,
    CYC_IO_WR,
    CYC_HALT_ACK,
    CYC_IPQ_FETCH,
    CYC_MEM_RD,
    CYC_MEM_WR
  } bus_cycle_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_READY
  } bus_state_e;

  localparam logic [15:0] c_idle_rdata = 16'hffff;

  // Status code is {m_io, r_w, busst1, busst0}.
  function automatic bus_cycle_e decode_bus_status(input logic [3:0] code);
    case (code)
      4'b0100: return CYC_INT_ACK;
      4'b0101: return CYC_IO_RD;
      4'b0001: return CYC_IO_WR;
      4'b0011: return CYC_HALT_ACK;
      4'b1100: return CYC_IPQ_FETCH;
      4'b1101: return CYC_MEM_RD;
      4'b1001: return CYC_MEM_WR;
      default: return CYC_NONE;
    endcase
  endfunction

  function automatic logic is_mem_read(input bus_cycle_e cyc);
    return (cyc == CYC_MEM_RD) || (cyc == CYC_IPQ_FETCH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_target.sv
// ============================================================================
// Module : bus_target
// Brief  : V33 bus responder with programmable wait states and memory/IO ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_target
  import bus_target_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 1,
  parameter int MEM_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_1,
  input  logic        ce_2,
  input  logic        n_bcyst,
  input  logic        n_dstb,
  input  logic        r_w,
  input  logic        m_io,
  input  logic        busst0,
  input  logic        busst1,
  input  logic        n_ube,
  input  logic [23:0] addr,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        n_ready,
  output logic [22:0] mem_addr,
  output logic        mem_rd,
  output logic [1:0]  mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] io_addr,
  output logic        io_rd,
  output logic [1:0]  io_we,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  input  logic [7:0]  int_vector,
  output logic        int_ack_done,
  output logic        halted,
  output logic        protocol_fault
);

  bus_state_e  r_state;
  bus_cycle_e  r_cyc;
  logic [23:0] r_addr;
  logic [1:0]  r_be;
  logic        r_undec;
  logic [7:0]  r_cnt;
  logic        r_int_phase;

  bus_cycle_e  w_cyc;
  logic        w_undec;
  logic        w_unused;

  assign w_cyc    = decode_bus_status({m_io, r_w, busst1, busst0});
  assign w_undec  = (addr >> MEM_BITS) != 24'd0;
  assign w_unused = n_dstb;
  assign mem_addr = r_addr[23:1];
  assign io_addr  = r_addr[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_cyc          <= CYC_NONE;
      r_addr         <= '0;
      r_be           <= '0;
      r_undec        <= 1'b0;
      r_cnt          <= '0;
      r_int_phase    <= 1'b0;
      n_ready        <= 1'b1;
      bus_rdata      <= c_idle_rdata;
      mem_rd         <= 1'b0;
      mem_we         <= 2'b00;
      mem_wdata      <= '0;
      io_rd          <= 1'b0;
      io_we          <= 2'b00;
      io_wdata       <= '0;
      int_ack_done   <= 1'b0;
      halted         <= 1'b0;
      protocol_fault <= 1'b0;
    end else begin
      mem_rd       <= 1'b0;
      mem_we       <= 2'b00;
      io_rd        <= 1'b0;
      io_we        <= 2'b00;
      int_ack_done <= 1'b0;

      if (ce_2 && !n_bcyst && (r_state != ST_IDLE)) protocol_fault <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (ce_2 && !n_bcyst) begin
            r_cyc   <= w_cyc;
            r_addr  <= addr;
            r_be    <= {~n_ube, ~addr[0]};
            r_undec <= w_undec;
            // IO-space codes (including INT_ACK/HALT_ACK) take the IO wait count.
            r_cnt   <= m_io ? 8'(MEM_WAIT) : 8'(IO_WAIT);
            mem_rd  <= is_mem_read(w_cyc) && !w_undec;
            io_rd   <= (w_cyc == CYC_IO_RD);
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ce_1) begin
            case (r_cyc)
              CYC_MEM_RD, CYC_IPQ_FETCH: bus_rdata <= r_undec ? c_idle_rdata : mem_rdata;
              CYC_MEM_WR: begin
                if (!r_undec) begin
                  mem_we    <= r_be;
                  mem_wdata <= bus_wdata;
                end
              end
              CYC_IO_RD: bus_rdata <= io_rdata;
              CYC_IO_WR: begin
                io_we    <= r_be;
                io_wdata <= bus_wdata;
              end
              CYC_INT_ACK: begin
                bus_rdata   <= r_int_phase ? {8'hff, int_vector} : c_idle_rdata;
                r_int_phase <= ~r_int_phase;
              end
              default: ;
            endcase
            halted <= (r_cyc == CYC_HALT_ACK);
            if (r_cnt == 8'd0) begin
              n_ready <= 1'b0;
              r_state <= ST_READY;
            end else begin
              r_cnt   <= r_cnt - 8'd1;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (ce_1) begin
            if (r_cnt == 8'd0) begin
              n_ready <= 1'b0;
              r_state <= ST_READY;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        ST_READY: begin
          if (ce_2) begin
            n_ready <= 1'b1;
            // Phase already toggled at ADDR, so a cleared phase marks the second acknowledge.
            int_ack_done <= (r_cyc == CYC_INT_ACK) && !r_int_phase;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_target.sv
// ============================================================================
// Module : tb_bus_target
// Brief  : Self-checking bench for bus_target with a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bus_target;

  localparam int MEM_WAIT = 0;
  localparam int IO_WAIT  = 2;
  localparam int MEM_BITS = 20;

  localparam int K_NONE = 0, K_INT = 1, K_IORD = 2, K_IOWR = 3, K_HALT = 4,
                 K_IPQ = 5, K_MRD = 6, K_MWR = 7;
  localparam logic [2:0] E_MRD = 3'd1, E_MWR = 3'd2, E_IORD = 3'd3, E_IOWR = 3'd4, E_DONE = 3'd5;

  typedef struct packed {
    logic [2:0]  k;
    logic [22:0] a;
    logic [1:0]  we;
    logic [15:0] d;
  } ev_t;

  logic        clk, reset, n_bcyst, n_dstb, r_w, m_io, busst0, busst1, n_ube;
  logic        ce_1, ce_2;
  logic [23:0] addr;
  logic [15:0] bus_wdata, bus_rdata, mem_wdata, mem_rdata, io_wdata, io_rdata;
  logic [22:0] mem_addr;
  logic [15:0] io_addr;
  logic        n_ready, mem_rd, io_rd, int_ack_done, halted, protocol_fault;
  logic [1:0]  mem_we, io_we;
  logic [7:0]  int_vector;
  logic [1:0]  ph;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  ev_t         exp_q[$];
  logic [15:0] model_rdata, exp_rdata, mem_resp, io_resp;
  logic        exp_halted, exp_fault, model_second;
  logic [1:0]  last_mem_we;

  bus_target #(.MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT), .MEM_BITS(MEM_BITS)) dut (
    .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2), .n_bcyst(n_bcyst), .n_dstb(n_dstb),
    .r_w(r_w), .m_io(m_io), .busst0(busst0), .busst1(busst1), .n_ube(n_ube), .addr(addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .n_ready(n_ready), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_addr(io_addr), .io_rd(io_rd), .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .int_vector(int_vector), .int_ack_done(int_ack_done), .halted(halted),
    .protocol_fault(protocol_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Four-clk T-state: ce_1 and ce_2 two clks apart so backend read data settles.
  initial ph = 2'd0;
  always @(posedge clk) ph <= ph + 2'd1;
  assign ce_1 = (ph == 2'd0);
  assign ce_2 = (ph == 2'd2);

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_resp;
    if (io_rd)  io_rdata  <= io_resp;
  end

  function automatic ev_t mk_ev(input logic [2:0] k, input logic [22:0] a,
                                input logic [1:0] we, input logic [15:0] d);
    return {k, a, we, d};
  endfunction

  function automatic int kind_of(input logic [3:0] code);
    case (code)
      4'b0100: return K_INT;
      4'b0101: return K_IORD;
      4'b0001: return K_IOWR;
      4'b0011: return K_HALT;
      4'b1100: return K_IPQ;
      4'b1101: return K_MRD;
      4'b1001: return K_MWR;
      default: return K_NONE;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  task automatic check_ev(input ev_t got);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL strobe_unexpected: got k=%0d a=%h we=%b d=%h expected none",
               got.k, got.a, got.we, got.d);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        n_fail++;
        $display("FAIL strobe: got k=%0d a=%h we=%b d=%h expected k=%0d a=%h we=%b d=%h",
                 got.k, got.a, got.we, got.d, e.k, e.a, e.we, e.d);
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (mem_rd) check_ev(mk_ev(E_MRD, mem_addr, 2'b00, 16'h0));
    if (mem_we != 2'b00) begin
      last_mem_we = mem_we;
      check_ev(mk_ev(E_MWR, mem_addr, mem_we, mem_wdata));
    end
    if (io_rd) check_ev(mk_ev(E_IORD, {7'b0, io_addr}, 2'b00, 16'h0));
    if (io_we != 2'b00) check_ev(mk_ev(E_IOWR, {7'b0, io_addr}, io_we, io_wdata));
    if (int_ack_done) begin
      n_done++;
      check_ev(mk_ev(E_DONE, 23'h0, 2'b00, 16'h0));
    end
    n_tests++;
    if (protocol_fault !== exp_fault) begin
      n_fail++;
      $display("FAIL protocol_fault: got %b expected %b", protocol_fault, exp_fault);
    end
    if (!reset && n_ready === 1'b0) begin
      n_tests++;
      if (bus_rdata !== exp_rdata || halted !== exp_halted) begin
        n_fail++;
        $display("FAIL ready_outputs: got rdata=%h halted=%b expected rdata=%h halted=%b",
                 bus_rdata, halted, exp_rdata, exp_halted);
      end
    end
  end

  task automatic bus_cycle(input logic [3:0] code, input logic [23:0] a, input logic nube,
                           input logic [15:0] wd, input bit glitch,
                           output int tw, output logic [15:0] rd);
    int   kind;
    int   waits;
    logic [1:0] be;
    logic undec;
    bit   got_ready;
    bit   glitched;
    kind  = kind_of(code);
    waits = code[3] ? MEM_WAIT : IO_WAIT;
    be    = {~nube, ~a[0]};
    undec = (a >> MEM_BITS) != 24'd0;
    case (kind)
      K_MRD, K_IPQ: begin
        if (!undec) exp_q.push_back(mk_ev(E_MRD, a[23:1], 2'b00, 16'h0));
        model_rdata = undec ? 16'hffff : mem_resp;
      end
      K_MWR: if (!undec && be != 2'b00) exp_q.push_back(mk_ev(E_MWR, a[23:1], be, wd));
      K_IORD: begin
        exp_q.push_back(mk_ev(E_IORD, {7'b0, a[15:0]}, 2'b00, 16'h0));
        model_rdata = io_resp;
      end
      K_IOWR: if (be != 2'b00) exp_q.push_back(mk_ev(E_IOWR, {7'b0, a[15:0]}, be, wd));
      K_INT: begin
        model_rdata = model_second ? {8'hff, int_vector} : 16'hffff;
        if (model_second) exp_q.push_back(mk_ev(E_DONE, 23'h0, 2'b00, 16'h0));
        model_second = !model_second;
      end
      default: ;
    endcase
    exp_rdata  = model_rdata;
    exp_halted = (kind == K_HALT);

    do @(negedge clk); while (ce_2 !== 1'b1);
    {m_io, r_w, busst1, busst0} = code;
    addr = a; n_ube = nube; bus_wdata = wd; n_bcyst = 1'b0;
    @(negedge clk);
    n_bcyst = 1'b1;
    tw = 0; got_ready = 0; glitched = 0;
    for (int i = 0; i < 64 && !got_ready; i++) begin
      @(negedge clk);
      if (ce_2) begin
        if (n_ready === 1'b0) got_ready = 1;
        else begin
          tw++;
          if (glitch && !glitched) begin
            glitched  = 1;
            n_bcyst   = 1'b0;
            exp_fault = 1'b1;
            @(negedge clk);
            n_bcyst = 1'b1;
          end
        end
      end
    end
    rd = bus_rdata;
    @(negedge clk);
    chk("ready_seen", {31'b0, got_ready}, 32'd1);
    chk("wait_states", tw, waits);
    chk("cycle_rdata", {16'h0, rd}, {16'h0, model_rdata});
    chk("strobes_all_seen", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          tw;
    logic [15:0] rd;
    reset = 1'b1; n_bcyst = 1'b1; n_dstb = 1'b1; r_w = 1'b1; m_io = 1'b1;
    busst0 = 1'b1; busst1 = 1'b1; n_ube = 1'b1; addr = '0; bus_wdata = '0;
    int_vector = 8'h21; mem_resp = '0; io_resp = '0; mem_rdata = '0; io_rdata = '0;
    model_rdata = 16'hffff; exp_rdata = 16'hffff; exp_halted = 1'b0; exp_fault = 1'b0;
    model_second = 1'b0; last_mem_we = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_n_ready", {31'b0, n_ready}, 32'd1);
    chk("rst_bus_rdata", {16'h0, bus_rdata}, 32'h0000ffff);
    chk("rst_strobes", {26'b0, mem_rd, mem_we, io_rd, io_we}, 32'd0);
    chk("rst_flags", {29'b0, int_ack_done, halted, protocol_fault}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    mem_resp = 16'hbeef;
    bus_cycle(4'b1101, 24'h001234, 1'b0, 16'h0, 0, tw, rd);
    chk("memrd_din", {16'h0, rd}, 32'h0000beef);
    chk("memrd_word_addr", {9'b0, mem_addr}, 32'h0000091a);
    chk("memrd_zero_wait", tw, 0);

    bus_cycle(4'b1001, 24'h000101, 1'b0, 16'h3412, 0, tw, rd);
    chk("odd_write_we", {30'b0, last_mem_we}, 32'd2);
    chk("write_keeps_rdata", {16'h0, bus_rdata}, 32'h0000beef);

    // Reset across the ce_1 that would strobe the write.
    do @(negedge clk); while (ce_2 !== 1'b1);
    {m_io, r_w, busst1, busst0} = 4'b1001;
    addr = 24'h000200; n_ube = 1'b0; bus_wdata = 16'h5555; n_bcyst = 1'b0;
    @(negedge clk);
    n_bcyst = 1'b1; reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_n_ready", {31'b0, n_ready}, 32'd1);
    chk("abort_rdata", {16'h0, bus_rdata}, 32'h0000ffff);
    reset = 1'b0;
    model_rdata = 16'hffff; exp_rdata = 16'hffff; model_second = 1'b0; exp_halted = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_idle_ready", {31'b0, n_ready}, 32'd1);

    io_resp = 16'h5a5a;
    bus_cycle(4'b0101, 24'h000040, 1'b1, 16'h0, 0, tw, rd);
    chk("iord_two_tw", tw, 2);
    chk("iord_data", {16'h0, rd}, 32'h00005a5a);

    bus_cycle(4'b0100, 24'h000000, 1'b1, 16'h0, 0, tw, rd);
    chk("intack1_data", {16'h0, rd}, 32'h0000ffff);
    chk("intack1_no_done", n_done, 0);
    bus_cycle(4'b0100, 24'h000000, 1'b1, 16'h0, 0, tw, rd);
    chk("intack2_data", {16'h0, rd}, 32'h0000ff21);
    chk("intack2_one_done", n_done, 1);

    bus_cycle(4'b0011, 24'h000000, 1'b1, 16'h0, 0, tw, rd);
    chk("halt_set", {31'b0, halted}, 32'd1);
    mem_resp = 16'h9090;
    bus_cycle(4'b1100, 24'h000010, 1'b0, 16'h0, 0, tw, rd);
    chk("halt_cleared", {31'b0, halted}, 32'd0);
    chk("ipq_data", {16'h0, rd}, 32'h00009090);

    bus_cycle(4'b0001, 24'h000041, 1'b1, 16'hdead, 0, tw, rd);
    bus_cycle(4'b0001, 24'h000044, 1'b0, 16'habcd, 0, tw, rd);

    io_resp = 16'h0102;
    bus_cycle(4'b0101, 24'h000042, 1'b1, 16'h0, 1, tw, rd);
    chk("fault_set", {31'b0, protocol_fault}, 32'd1);

    mem_resp = 16'h7777;
    bus_cycle(4'b1101, 24'h100000, 1'b0, 16'h0, 0, tw, rd);
    chk("undecoded_rdata", {16'h0, rd}, 32'h0000ffff);
    chk("fault_sticky", {31'b0, protocol_fault}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
